// File: rtl/syscall_exec.sv
// syscall_exec: execution stage behind the syscall decoder.
// Accepts one-hot syscall strobes and runs each operation as a multi-cycle
// sequence. It uses the data-memory read port, the register-file read port
// and a byte-wide output stream with a valid/ready handshake.
// Optional feature macro: SYSCALL_TIMEOUT_EN. When it is defined, an EMIT that
// waits TIMEOUT cycles with out_ready low is abandoned, and err and done
// pulse together.
//
// State | meaning
// IDLE  | waiting for a strobe; stall follows the strobe combinationally
// FETCH | issue memory read, select a register, or pick the next byte
// WAIT  | memory data returns (get_int writes acc here)
// EMIT  | byte presented on the output stream until handshake
// DONE  | one-cycle done pulse, strobes ignored
//
// Ports: clk, reset_n (async, active low); decoder strobes; acc, sp;
// mem_rd/mem_addr/mem_rdata (1-cycle read latency); reg_sel/reg_rdata
// (combinational); out_valid/out_data/out_kind/out_ready stream;
// acc_we/acc_wdata; stall, done, err.
module syscall_exec #(
  parameter int REG_COUNT = 4,
  parameter int MAX_STR   = 64,
  parameter int TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       get_int,
  input  logic       print_string,
  input  logic       print_acc,
  input  logic       print_regs,
  input  logic       print_stack,
  input  logic [7:0] acc,
  input  logic [7:0] sp,
  output logic       mem_rd,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic [2:0] reg_sel,
  input  logic [7:0] reg_rdata,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [1:0] out_kind,
  input  logic       out_ready,
  output logic       acc_we,
  output logic [7:0] acc_wdata,
  output logic       stall,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EMIT, S_DONE} state_t;
  typedef enum logic [2:0] {OP_GET, OP_STR, OP_ACC, OP_REGS, OP_STACK} op_t;

  localparam int            CW       = $clog2(MAX_STR + 1);
  localparam logic [CW-1:0] STR_LAST = CW'(MAX_STR - 1);
  localparam logic [3:0]    IDX_ACC  = 4'(REG_COUNT);
  localparam logic [3:0]    IDX_SP   = 4'(REG_COUNT + 1);
  localparam logic [1:0]    K_CHAR   = 2'b00;
  localparam logic [1:0]    K_INT    = 2'b01;
  localparam logic [1:0]    K_SEP    = 2'b10;

  state_t        state, state_nxt;
  op_t           op, op_sel;
  logic [7:0]    acc_l, sp_l, ptr, byte_r;
  logic [1:0]    kind_r;
  logic          nl_r;
  logic [CW-1:0] cnt;
  logic [3:0]    idx;
  logic          req, accept, xfer, stk_more, to_hit;

  assign req      = get_int | print_string | print_acc | print_regs | print_stack;
  assign accept   = (state == S_IDLE) && req;
  assign stk_more = ptr > sp_l;
  assign xfer     = (state == S_EMIT) && out_ready && !to_hit;

  always_comb begin
    if (get_int)           op_sel = OP_GET;
    else if (print_string) op_sel = OP_STR;
    else if (print_acc)    op_sel = OP_ACC;
    else if (print_regs)   op_sel = OP_REGS;
    else                   op_sel = OP_STACK;
  end

`ifdef SYSCALL_TIMEOUT_EN
  logic [7:0] to_cnt;
  assign to_hit = (state == S_EMIT) && (to_cnt == 8'(TIMEOUT));
  assign err    = to_hit;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                      to_cnt <= '0;
    else if (state == S_EMIT && !out_ready && !to_hit) to_cnt <= to_cnt + 8'd1;
    else                                               to_cnt <= '0;
  end
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_addr  = 8'h00;
    reg_sel   = 3'd0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_kind  = 2'b00;
    acc_we    = 1'b0;
    acc_wdata = 8'h00;
    stall     = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        // gated by reset_n so every output reads 0 while reset is held
        if (accept && reset_n) begin
          stall     = 1'b1;
          state_nxt = (op_sel == OP_ACC) ? S_EMIT : S_FETCH;
        end
      end
      S_FETCH: begin
        stall = 1'b1;
        case (op)
          OP_GET, OP_STR: begin
            mem_rd    = 1'b1;
            mem_addr  = ptr;
            state_nxt = S_WAIT;
          end
          OP_STACK: begin
            if (stk_more) begin
              mem_rd    = 1'b1;
              mem_addr  = ptr;
              state_nxt = S_WAIT;
            end else begin
              state_nxt = S_EMIT;
            end
          end
          default: begin
            if (idx < IDX_ACC) reg_sel = idx[2:0];
            state_nxt = S_EMIT;
          end
        endcase
      end
      S_WAIT: begin
        stall = 1'b1;
        if (op == OP_GET) begin
          acc_we    = 1'b1;
          acc_wdata = mem_rdata;
          state_nxt = S_DONE;
        end else if (op == OP_STR && mem_rdata == 8'h00) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        stall = 1'b1;
        if (to_hit) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          out_valid = 1'b1;
          out_data  = byte_r;
          out_kind  = kind_r;
          if (out_ready) begin
            if (op == OP_ACC || nl_r)                  state_nxt = S_DONE;
            else if (op == OP_STR && cnt == STR_LAST)  state_nxt = S_EMIT;
            else                                       state_nxt = S_FETCH;
          end
        end
      end
      S_DONE: begin
        stall     = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op     <= OP_GET;
      acc_l  <= 8'h00;
      sp_l   <= 8'h00;
      ptr    <= 8'h00;
      byte_r <= 8'h00;
      kind_r <= 2'b00;
      nl_r   <= 1'b0;
      cnt    <= '0;
      idx    <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op     <= op_sel;
            acc_l  <= acc;
            sp_l   <= sp;
            ptr    <= (op_sel == OP_STACK) ? 8'hFF : acc;
            byte_r <= acc;
            kind_r <= K_INT;
            nl_r   <= 1'b0;
            cnt    <= '0;
            idx    <= 4'd0;
          end
        end
        S_FETCH: begin
          if (op == OP_REGS) begin
            if (idx < IDX_ACC) begin
              byte_r <= reg_rdata;
              kind_r <= K_INT;
            end else if (idx == IDX_ACC) begin
              byte_r <= acc_l;
              kind_r <= K_INT;
            end else if (idx == IDX_SP) begin
              byte_r <= sp_l;
              kind_r <= K_INT;
            end else begin
              byte_r <= 8'h0A;
              kind_r <= K_SEP;
              nl_r   <= 1'b1;
            end
          end else if (op == OP_STACK && !stk_more) begin
            byte_r <= 8'h0A;
            kind_r <= K_SEP;
            nl_r   <= 1'b1;
          end
        end
        S_WAIT: begin
          byte_r <= mem_rdata;
          kind_r <= (op == OP_STR) ? K_CHAR : K_INT;
        end
        S_EMIT: begin
          if (xfer) begin
            case (op)
              OP_STR: begin
                cnt <= cnt + 1'b1;
                ptr <= ptr + 8'd1;
                // string length cap reached: the newline follows directly
                if (cnt == STR_LAST) begin
                  byte_r <= 8'h0A;
                  kind_r <= K_SEP;
                  nl_r   <= 1'b1;
                end
              end
              OP_STACK: ptr <= ptr - 8'd1;
              OP_REGS:  idx <= idx + 4'd1;
              default:  ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_exec.sv
// tb_syscall_exec: directed self-checking bench for syscall_exec.
// Memory and register file are modelled here; the byte stream is captured
// into queues and compared against hand-computed expectations.
module tb_syscall_exec;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       get_int = 0, print_string = 0, print_acc = 0, print_regs = 0, print_stack = 0;
  logic [7:0] acc = 8'h00, sp = 8'h00;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic [2:0] reg_sel;
  logic [7:0] reg_rdata;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_kind;
  logic       out_ready = 1'b1;
  logic       acc_we;
  logic [7:0] acc_wdata;
  logic       stall, done, err;

  logic [7:0] mem [256];
  logic [7:0] regs [8];

  int checks = 0;
  int errors = 0;

  logic [7:0] q_data [$];
  logic [1:0] q_kind [$];
  logic       stable_ok;
  logic       got_done;

  syscall_exec dut (
    .clk(clk), .reset_n(reset_n),
    .get_int(get_int), .print_string(print_string), .print_acc(print_acc),
    .print_regs(print_regs), .print_stack(print_stack),
    .acc(acc), .sp(sp),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .reg_sel(reg_sel), .reg_rdata(reg_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_kind(out_kind), .out_ready(out_ready),
    .acc_we(acc_we), .acc_wdata(acc_wdata),
    .stall(stall), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];
  assign reg_rdata = regs[reg_sel];

  task automatic clear_strobes();
    get_int = 0; print_string = 0; print_acc = 0; print_regs = 0; print_stack = 0;
  endtask

  // Strobe is already asserted at the current negedge. mode 0: ready high,
  // 1: ready toggling, 2: ready low. Stops on done or after max_cyc cycles.
  task automatic run_op(input int mode, input int max_cyc);
    logic       hold;
    logic [7:0] hd;
    logic [1:0] hk;
    int         n;
    q_data.delete(); q_kind.delete();
    stable_ok = 1'b1; got_done = 1'b0; hold = 1'b0; hd = 0; hk = 0; n = 0;
    while (!got_done && n < max_cyc) begin
      @(negedge clk);
      n++;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? n[0] : 1'b0;
      #1;
      if (hold && (!out_valid || out_data !== hd || out_kind !== hk)) stable_ok = 1'b0;
      if (out_valid && out_ready) begin
        q_data.push_back(out_data);
        q_kind.push_back(out_kind);
      end
      hold = out_valid && !out_ready;
      hd = out_data; hk = out_kind;
      if (done) begin
        got_done = 1'b1;
        clear_strobes();
      end
    end
    clear_strobes();
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if ({mem_rd, mem_addr, reg_sel, out_valid, out_data, out_kind, acc_we, acc_wdata,
         stall, done, err} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs stall=%b done=%b out_valid=%b mem_rd=%b acc_we=%b want all 0",
               stall, done, out_valid, mem_rd, acc_we);
    end
    reset_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL reset_idle_stall got %b want 0", stall);
    end
  endtask

  task automatic test_get_int();
    mem[8'h20] = 8'h5A;
    @(negedge clk);
    acc = 8'h20; get_int = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL get_int_stall_c0 got %b want 1", stall); end
    @(negedge clk); #1;
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 8'h20) begin
      errors++; $display("FAIL get_int_c1_read mem_rd=%b addr=%h want 1 20", mem_rd, mem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (acc_we !== 1'b1 || acc_wdata !== 8'h5A) begin
      errors++; $display("FAIL get_int_c2_write acc_we=%b data=%h want 1 5a", acc_we, acc_wdata);
    end
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL get_int_c3_done done=%b out_valid=%b want 1 0", done, out_valid);
    end
    clear_strobes();
    @(negedge clk); #1;
    checks++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL get_int_idle stall=%b done=%b want 0 0", stall, done);
    end
  endtask

  task automatic test_string_hi();
    logic [7:0] exp [3];
    exp[0] = 8'h48; exp[1] = 8'h69; exp[2] = 8'h21;
    mem[8'h10] = 8'h48; mem[8'h11] = 8'h69; mem[8'h12] = 8'h21; mem[8'h13] = 8'h00;
    mem[8'h14] = 8'h55;
    @(negedge clk);
    acc = 8'h10; print_string = 1'b1;
    run_op(1, 100);
    checks++;
    if (got_done !== 1'b1) begin errors++; $display("FAIL str_hi_done got %b want 1", got_done); end
    checks++;
    if (q_data.size() != 3) begin
      errors++; $display("FAIL str_hi_count got %0d want 3", q_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q_data[i] !== exp[i] || q_kind[i] !== 2'b00) begin
          errors++;
          $display("FAIL str_hi_byte%0d got %h/%b want %h/00", i, q_data[i], q_kind[i], exp[i]);
        end
      end
    end
    checks++;
    if (stable_ok !== 1'b1) begin errors++; $display("FAIL str_hi_stable got %b want 1", stable_ok); end
  endtask

  task automatic test_string_wrap();
    logic [7:0] a;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) | 8'h01;
    @(negedge clk);
    acc = 8'hFE; print_string = 1'b1;
    run_op(0, 400);
    checks++;
    if (got_done !== 1'b1 || q_data.size() != 65) begin
      errors++;
      $display("FAIL str_wrap_count done=%b bytes=%0d want 1 65", got_done, q_data.size());
    end else begin
      for (int k = 0; k < 64; k++) begin
        a = 8'hFE + 8'(k);
        checks++;
        if (q_data[k] !== (a | 8'h01) || q_kind[k] !== 2'b00) begin
          errors++;
          $display("FAIL str_wrap_byte%0d got %h/%b want %h/00", k, q_data[k], q_kind[k], a | 8'h01);
        end
      end
      checks++;
      if (q_data[64] !== 8'h0A || q_kind[64] !== 2'b10) begin
        errors++; $display("FAIL str_wrap_newline got %h/%b want 0a/10", q_data[64], q_kind[64]);
      end
    end
  endtask

  task automatic test_print_stack();
    logic [7:0] exp [4];
    logic [1:0] ek  [4];
    exp[0] = 8'h01; exp[1] = 8'h02; exp[2] = 8'h03; exp[3] = 8'h0A;
    ek[0] = 2'b01; ek[1] = 2'b01; ek[2] = 2'b01; ek[3] = 2'b10;
    mem[8'hFF] = 8'h01; mem[8'hFE] = 8'h02; mem[8'hFD] = 8'h03; mem[8'hFC] = 8'h77;
    @(negedge clk);
    sp = 8'hFC; print_stack = 1'b1;
    run_op(0, 100);
    checks++;
    if (got_done !== 1'b1 || q_data.size() != 4) begin
      errors++; $display("FAIL stack_count done=%b bytes=%0d want 1 4", got_done, q_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_data[i] !== exp[i] || q_kind[i] !== ek[i]) begin
          errors++;
          $display("FAIL stack_byte%0d got %h/%b want %h/%b", i, q_data[i], q_kind[i], exp[i], ek[i]);
        end
      end
    end
    @(negedge clk);
    sp = 8'hFF; print_stack = 1'b1;
    run_op(0, 50);
    checks++;
    if (got_done !== 1'b1 || q_data.size() != 1) begin
      errors++; $display("FAIL stack_empty_count done=%b bytes=%0d want 1 1", got_done, q_data.size());
    end else begin
      checks++;
      if (q_data[0] !== 8'h0A || q_kind[0] !== 2'b10) begin
        errors++; $display("FAIL stack_empty_nl got %h/%b want 0a/10", q_data[0], q_kind[0]);
      end
    end
  endtask

  task automatic test_print_regs();
    logic [7:0] exp [7];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
    exp[4] = 8'h07; exp[5] = 8'hF0; exp[6] = 8'h0A;
    regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33; regs[3] = 8'h44;
    @(negedge clk);
    acc = 8'h07; sp = 8'hF0; print_regs = 1'b1;
    run_op(1, 100);
    checks++;
    if (got_done !== 1'b1 || q_data.size() != 7) begin
      errors++; $display("FAIL regs_count done=%b bytes=%0d want 1 7", got_done, q_data.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (q_data[i] !== exp[i] || q_kind[i] !== ((i == 6) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL regs_byte%0d got %h/%b want %h", i, q_data[i], q_kind[i], exp[i]);
        end
      end
    end
    checks++;
    if (stable_ok !== 1'b1) begin errors++; $display("FAIL regs_stable got %b want 1", stable_ok); end
  endtask

  task automatic test_priority();
    @(negedge clk);
    acc = 8'h3C; sp = 8'hFC; print_acc = 1'b1; print_regs = 1'b1; print_stack = 1'b1;
    run_op(0, 50);
    checks++;
    if (got_done !== 1'b1 || q_data.size() != 1) begin
      errors++; $display("FAIL prio_count done=%b bytes=%0d want 1 1", got_done, q_data.size());
    end else begin
      checks++;
      if (q_data[0] !== 8'h3C || q_kind[0] !== 2'b01) begin
        errors++; $display("FAIL prio_acc got %h/%b want 3c/01", q_data[0], q_kind[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    mem[8'h10] = 8'h48; mem[8'h11] = 8'h69; mem[8'h12] = 8'h00;
    @(negedge clk);
    acc = 8'h10; out_ready = 1'b0; print_string = 1'b1;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!out_valid && n < 20);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_emit got %b want 1", out_valid); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_rd, mem_addr, reg_sel, out_valid, out_data, out_kind, acc_we, acc_wdata,
         stall, done, err} !== 35'd0) begin
      errors++;
      $display("FAIL rstmid_outputs stall=%b out_valid=%b out_data=%h want all 0",
               stall, out_valid, out_data);
    end
    @(negedge clk);
    clear_strobes(); out_ready = 1'b1; reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (stall !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_idle%0d stall=%b done=%b out_valid=%b want 0 0 0", i, stall, done, out_valid);
      end
    end
  endtask

`ifdef SYSCALL_TIMEOUT_EN
  task automatic test_timeout();
    int stalled;
    int n;
    logic seen;
    @(negedge clk);
    acc = 8'h99; print_acc = 1'b1; out_ready = 1'b0;
    stalled = 0; n = 0; seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk); #1; n++;
      if (err) begin
        seen = 1'b1;
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
          errors++; $display("FAIL timeout_pulse done=%b out_valid=%b want 1 0", done, out_valid);
        end
      end else if (out_valid) stalled++;
    end
    clear_strobes(); out_ready = 1'b1;
    checks++;
    if (seen !== 1'b1 || stalled != 255) begin
      errors++; $display("FAIL timeout_len seen=%b stalled=%0d want 1 255", seen, stalled);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    test_reset();
    test_get_int();
    test_string_hi();
    test_string_wrap();
    test_print_stack();
    test_print_regs();
    test_priority();
    test_reset_mid();
`ifdef SYSCALL_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/syscall_exec.md
Name: syscall_exec

Overview:
- Execution stage directly downstream of the syscall decoder.
- Consumes the one-hot syscall strobes (get_int, print_string, print_acc, print_regs, print_stack) and performs the operation as a multi-cycle sequence.
- Operations use the data-memory read port, the register-file read port and a byte-wide output stream to the host/console model.
- Stalls the CPU from acceptance until completion.

Parameters:
- REG_COUNT, 4: number of addressable registers dumped by print_regs, plus ACC and SP appended.
- MAX_STR, 64: maximum bytes emitted by print_string before forced termination.
- TIMEOUT, 255: out_ready-low cycle limit; used only with SYSCALL_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- get_int, print_string, print_acc, print_regs, print_stack  in  1 each  decoder strobes; at most one high; held level while the instruction is held.
- acc  in  8  accumulator value.
- sp  in  8  stack pointer; the stack grows down from 0xFF; sp points to the next free slot.
- mem_rd  out  1  memory read request.
- mem_addr  out  8  memory read address.
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd.
- reg_sel  out  3  register-file read select.
- reg_rdata  in  8  combinational register read data.
- out_valid  out  1  output byte valid.
- out_data  out  8  output byte.
- out_kind  out  2  00 char, 01 integer, 10 separator/newline.
- out_ready  in  1  consumer ready.
- acc_we  out  1  one-cycle accumulator write strobe.
- acc_wdata  out  8  accumulator write data.
- stall  out  1  high while busy.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse; only with SYSCALL_TIMEOUT_EN.

Behaviour:
- Reset: all outputs 0; state IDLE; internal pointer and counters 0. Asynchronous assertion aborts any operation immediately; no done pulse is issued.
- States: IDLE, FETCH, WAIT, EMIT, DONE.
- IDLE: any strobe high → latch the operation, acc and sp, and go to the operation's first state next cycle. stall rises in the acceptance cycle (combinationally from the strobe) and stays high through DONE. If several strobes are high, priority is get_int > print_string > print_acc > print_regs > print_stack.
- get_int: FETCH mem_rd=1, mem_addr=acc → WAIT. Next cycle acc_we=1, acc_wdata=mem_rdata → DONE. Total 3 cycles.
- print_acc: EMIT out_kind=01, out_data=latched acc → DONE on handshake.
- print_string: the pointer starts at the latched acc. Each loop is FETCH → WAIT → EMIT, with out_kind=00.
  - A byte of 0x00 is not emitted; go to DONE.
  - After MAX_STR bytes, emit a newline (kind 10, 0x0A), then DONE.
  - The pointer wraps 0xFF → 0x00.
- print_regs: for i = 0..REG_COUNT-1, reg_sel=i and emit reg_rdata as kind 01. Then emit latched acc, then latched sp, then a newline. Total REG_COUNT+3 bytes.
- print_stack: the pointer starts at 0xFF and emits mem[ptr] as kind 01 while ptr > latched sp, decrementing. If sp==0xFF, emit only a newline. All loops end with a newline.
- Output handshake: out_data and out_kind are held stable while out_valid=1 and out_ready=0. A transfer happens on the cycle where out_valid and out_ready are both high. out_valid never drops without a transfer.
- DONE: done=1 and stall=1 for one cycle → IDLE. Strobes seen in DONE are ignored. A strobe held in the IDLE cycle after DONE starts a new operation; the CPU must have advanced on done.
- Strobe changes after acceptance are ignored.

Optional Feature:
- SYSCALL_TIMEOUT_EN defined: a counter increments each EMIT cycle with out_ready=0 and clears on transfer. When it reaches TIMEOUT, drop out_valid, pulse err and done together, and go to IDLE.
- Undefined: no counter and no timeout; err is tied 0; EMIT waits indefinitely.

Test Plan:
- Reset mid print_string (reset_n low during EMIT) → all outputs 0 in the same cycle; after release, IDLE, stall=0, no done.
- get_int with acc=0x20, mem[0x20]=0x5A → mem_rd at cycle 1, acc_we=1 with acc_wdata=0x5A at cycle 2, done at cycle 3.
- print_string with acc=0x10, mem[0x10..0x13]="Hi!"+0x00, out_ready toggling 1/0 → bytes 0x48,0x69,0x21 with kind 00 and stable data under backpressure; 0x00 not emitted; then done.
- print_string with acc=0xFE and no terminator → pointer wraps to 0x00; exactly MAX_STR=64 bytes then a 0x0A newline; then done.
- print_stack with sp=0xFC and mem[0xFF..0xFD]=1,2,3 → integers 1,2,3 then newline. With sp=0xFF → newline only.
- print_regs with regs 0..3 = 0x11..0x44, acc=0x07, sp=0xF0 → 0x11,0x22,0x33,0x44,0x07,0xF0,0x0A. With SYSCALL_TIMEOUT_EN and out_ready held 0 → err and done pulse after 255 cycles.
